// File: rtl/puf_eval_if.sv
// Host-side request/response bundle for the PUF evaluation controller.
// The controller takes the slave modport; the challenge source takes the master modport.
interface puf_eval_if #(
    parameter int CW = 8,
    parameter int RW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic [CW-1:0] req_challenge;
    logic          abort;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [RW-1:0] rsp_data;
    logic [RW-1:0] rsp_unstable;
    logic          busy;

    modport master (
        output req_valid, req_challenge, abort, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_unstable, busy
    );

    modport slave (
        input  req_valid, req_challenge, abort, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_unstable, busy
    );
endinterface

// File: rtl/puf_eval_controller.sv
// Sequences an RO PUF array through clear -> measure -> settle -> capture per request.
// Define PUF_MAJORITY_VOTE_EN to run NUM_EVALS passes and majority-vote each response bit.
module puf_eval_controller #(
    parameter int CW            = 8,
    parameter int RW            = 8,
    parameter int CLEAR_CYCLES  = 4,
    parameter int MEAS_CYCLES   = 1024,
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_EVALS     = 3
) (
    input  logic          clk,
    input  logic          reset,
    puf_eval_if.slave     host,
    output logic [CW-1:0] puf_challenge,
    output logic          puf_reset,
    output logic          puf_en,
    input  logic [RW-1:0] puf_response
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MEAS,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam int MAX_A   = (CLEAR_CYCLES > MEAS_CYCLES) ? CLEAR_CYCLES : MEAS_CYCLES;
    localparam int MAX_CYC = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] CLEAR_LOAD  = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] MEAS_LOAD   = CNT_W'(MEAS_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    // An even vote count has no majority; this empty block makes a bad setting easy to spot.
    if ((NUM_EVALS % 2) == 0) begin : g_num_evals_must_be_odd
    end

    state_t         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CW-1:0]  chal_q, chal_d;
    logic [RW-1:0]  rsp_data_q, rsp_data_d;
    logic           req_ready_q, req_ready_d;
    logic           busy_q, busy_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           puf_reset_q, puf_reset_d;
    logic           puf_en_q, puf_en_d;

`ifdef PUF_MAJORITY_VOTE_EN
    localparam int VW = $clog2(NUM_EVALS + 1);
    localparam int EW = $clog2(NUM_EVALS + 1);
    localparam logic [VW-1:0] VOTE_HALF  = VW'(NUM_EVALS / 2);
    localparam logic [VW-1:0] VOTE_ALL   = VW'(NUM_EVALS);
    localparam logic [EW-1:0] EVAL_LAST  = EW'(NUM_EVALS - 1);

    logic [RW-1:0][VW-1:0] vote_q, vote_d, vote_sum;
    logic [EW-1:0]         eval_q, eval_d;
    logic [RW-1:0]         unst_q, unst_d;
    logic [RW-1:0]         maj_bits, unst_bits;

    // Per-bit tallies including the response being captured this cycle.
    for (genvar gi = 0; gi < RW; gi++) begin : g_vote
        assign vote_sum[gi]  = vote_q[gi] + VW'(puf_response[gi]);
        assign maj_bits[gi]  = (vote_sum[gi] > VOTE_HALF);
        assign unst_bits[gi] = (vote_sum[gi] != '0) && (vote_sum[gi] != VOTE_ALL);
    end
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        chal_d     = chal_q;
        rsp_data_d = rsp_data_q;
`ifdef PUF_MAJORITY_VOTE_EN
        vote_d     = vote_q;
        eval_d     = eval_q;
        unst_d     = unst_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (host.req_valid && req_ready_q) begin
                    state_d = S_CLEAR;
                    cnt_d   = CLEAR_LOAD;
                    chal_d  = host.req_challenge;
`ifdef PUF_MAJORITY_VOTE_EN
                    vote_d  = '0;
                    eval_d  = '0;
`endif
                end
            end
            S_CLEAR: begin
                if (cnt_q == '0) begin
                    state_d = S_MEAS;
                    cnt_d   = MEAS_LOAD;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            S_MEAS: begin
                if (cnt_q == '0) begin
                    state_d = S_SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            S_CAPTURE: begin
`ifdef PUF_MAJORITY_VOTE_EN
                vote_d = vote_sum;
                if (eval_q == EVAL_LAST) begin
                    state_d    = S_DONE;
                    rsp_data_d = maj_bits;
                    unst_d     = unst_bits;
                end else begin
                    state_d    = S_CLEAR;
                    cnt_d      = CLEAR_LOAD;
                    eval_d     = eval_q + EW'(1);
                end
`else
                state_d    = S_DONE;
                rsp_data_d = puf_response;
`endif
            end
            S_DONE: begin
                if (host.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything outside IDLE, including a coincident response handshake.
        if (host.abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
`ifdef PUF_MAJORITY_VOTE_EN
            vote_d  = '0;
            eval_d  = '0;
`endif
        end

        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        rsp_valid_d = (state_d == S_DONE);
        puf_reset_d = (state_d == S_IDLE) || (state_d == S_CLEAR);
        puf_en_d    = (state_d == S_MEAS);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            chal_q      <= '0;
            rsp_data_q  <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            puf_reset_q <= 1'b1;
            puf_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            chal_q      <= chal_d;
            rsp_data_q  <= rsp_data_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            puf_reset_q <= puf_reset_d;
            puf_en_q    <= puf_en_d;
        end
    end

`ifdef PUF_MAJORITY_VOTE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vote_q <= '0;
            eval_q <= '0;
            unst_q <= '0;
        end else begin
            vote_q <= vote_d;
            eval_q <= eval_d;
            unst_q <= unst_d;
        end
    end

    assign host.rsp_unstable = unst_q;
`else
    assign host.rsp_unstable = '0;
`endif

    assign host.req_ready = req_ready_q;
    assign host.busy      = busy_q;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_data  = rsp_data_q;
    assign puf_challenge  = chal_q;
    assign puf_reset      = puf_reset_q;
    assign puf_en         = puf_en_q;

endmodule

// File: tb/tb_puf_eval_controller.sv
// Directed bench for puf_eval_controller with CLEAR=2, MEAS=8, SETTLE=1, NUM_EVALS=3.
// Build with PUF_MAJORITY_VOTE_EN defined to also exercise the voting path.
module tb_puf_eval_controller;

`ifdef PUF_MAJORITY_VOTE_EN
    localparam int LAT = 37;
`else
    localparam int LAT = 13;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] puf_challenge;
    logic       puf_reset;
    logic       puf_en;
    logic [7:0] puf_response = 8'h00;

    int vectors = 0;
    int miscompares = 0;

    puf_eval_if #(.CW(8), .RW(8)) host_if ();

    puf_eval_controller #(
        .CW(8), .RW(8), .CLEAR_CYCLES(2), .MEAS_CYCLES(8),
        .SETTLE_CYCLES(1), .NUM_EVALS(3)
    ) dut (
        .clk          (clk),
        .reset        (rst_n),
        .host         (host_if),
        .puf_challenge(puf_challenge),
        .puf_reset    (puf_reset),
        .puf_en       (puf_en),
        .puf_response (puf_response)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Status vector order: {puf_reset, puf_en, rsp_valid, busy, req_ready}
    task automatic test_reset();
        logic [4:0] st;
        host_if.req_valid = 1'b0;
        host_if.req_challenge = 8'h00;
        host_if.abort = 1'b0;
        host_if.rsp_ready = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        st = {puf_reset, puf_en, host_if.rsp_valid, host_if.busy, host_if.req_ready};
        vectors++;
        if (st !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset_hold: status got %b expected %b", st, 5'b10000);
        end
        #3 rst_n = 1'b1;
        step();
        st = {puf_reset, puf_en, host_if.rsp_valid, host_if.busy, host_if.req_ready};
        vectors++;
        if (st !== 5'b10001) begin
            miscompares++;
            $display("FAIL reset_release: status got %b expected %b", st, 5'b10001);
        end
        vectors++;
        if ({puf_challenge, host_if.rsp_data, host_if.rsp_unstable} !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_data: chal/data/unst got %h expected 000000",
                     {puf_challenge, host_if.rsp_data, host_if.rsp_unstable});
        end
        $display("reset: released, controller idle");
    endtask

    task automatic test_single();
        logic [4:0] st, exp;
        int kk;
        host_if.req_challenge = 8'hA5;
        host_if.req_valid = 1'b1;
        puf_response = 8'h3C;
        step();
        host_if.req_valid = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            kk = (k - 1) % 12 + 1;
            if (k == LAT) exp = 5'b00110;
            else exp = {kk <= 2, (kk >= 3) && (kk <= 10), 1'b0, 1'b1, 1'b0};
            st = {puf_reset, puf_en, host_if.rsp_valid, host_if.busy, host_if.req_ready};
            vectors++;
            if (st !== exp) begin
                miscompares++;
                $display("FAIL single_seq cycle %0d: status got %b expected %b", k, st, exp);
            end
            vectors++;
            if (puf_challenge !== 8'hA5) begin
                miscompares++;
                $display("FAIL single_chal cycle %0d: got %h expected a5", k, puf_challenge);
            end
            if (k < LAT) step();
        end
        vectors++;
        if (host_if.rsp_data !== 8'h3C || host_if.rsp_unstable !== 8'h00) begin
            miscompares++;
            $display("FAIL single_data: data/unst got %h/%h expected 3c/00",
                     host_if.rsp_data, host_if.rsp_unstable);
        end
        $display("single: challenge a5 -> response %h after %0d cycles", host_if.rsp_data, LAT);
    endtask

    task automatic test_hold();
        puf_response = 8'h00;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if ({host_if.rsp_valid, host_if.req_ready, host_if.rsp_data} !== {2'b10, 8'h3C}) begin
                miscompares++;
                $display("FAIL hold_%0d: valid/ready/data got %b/%b/%h expected 1/0/3c",
                         i, host_if.rsp_valid, host_if.req_ready, host_if.rsp_data);
            end
        end
        host_if.rsp_ready = 1'b1;
        step();
        host_if.rsp_ready = 1'b0;
        vectors++;
        if ({host_if.req_ready, host_if.rsp_valid, host_if.busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL hold_release: ready/valid/busy got %b expected 100",
                     {host_if.req_ready, host_if.rsp_valid, host_if.busy});
        end
        $display("hold: response held 5 cycles then accepted");
    endtask

    task automatic test_abort_meas();
        logic [4:0] st;
        int lat;
        bit seen;
        host_if.req_challenge = 8'h5A;
        host_if.req_valid = 1'b1;
        puf_response = 8'hFF;
        step();
        host_if.req_valid = 1'b0;
        for (int k = 1; k < 5; k++) step();
        host_if.abort = 1'b1;
        step();
        host_if.abort = 1'b0;
        st = {puf_reset, puf_en, host_if.rsp_valid, host_if.busy, host_if.req_ready};
        vectors++;
        if (st !== 5'b10001) begin
            miscompares++;
            $display("FAIL abort_meas: status got %b expected 10001", st);
        end
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (host_if.rsp_valid) seen = 1'b1;
            step();
        end
        vectors++;
        if (seen || host_if.rsp_data !== 8'h3C) begin
            miscompares++;
            $display("FAIL abort_quiet: rsp seen %0d data %h expected 0 and 3c", seen, host_if.rsp_data);
        end
        host_if.req_challenge = 8'hC3;
        host_if.req_valid = 1'b1;
        puf_response = 8'h96;
        step();
        host_if.req_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            if (host_if.rsp_valid) begin
                lat = k;
                break;
            end
            step();
        end
        vectors++;
        if (lat != LAT || host_if.rsp_data !== 8'h96) begin
            miscompares++;
            $display("FAIL abort_recover: latency %0d data %h expected %0d and 96", lat, host_if.rsp_data, LAT);
        end
        host_if.rsp_ready = 1'b1;
        step();
        host_if.rsp_ready = 1'b0;
        $display("abort_meas: aborted c3-less run, next request latency %0d", lat);
    endtask

    task automatic test_abort_idle_done();
        int lat;
        host_if.req_challenge = 8'h81;
        host_if.req_valid = 1'b1;
        host_if.abort = 1'b1;
        puf_response = 8'h42;
        step();
        host_if.req_valid = 1'b0;
        host_if.abort = 1'b0;
        vectors++;
        if ({host_if.busy, puf_challenge} !== {1'b1, 8'h81}) begin
            miscompares++;
            $display("FAIL abort_idle: busy/chal got %b/%h expected 1/81", host_if.busy, puf_challenge);
        end
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            if (host_if.rsp_valid) begin
                lat = k;
                break;
            end
            step();
        end
        vectors++;
        if (lat != LAT) begin
            miscompares++;
            $display("FAIL abort_idle_lat: got %0d expected %0d", lat, LAT);
        end
        host_if.abort = 1'b1;
        host_if.rsp_ready = 1'b1;
        step();
        host_if.abort = 1'b0;
        host_if.rsp_ready = 1'b0;
        vectors++;
        if ({host_if.rsp_valid, host_if.req_ready, host_if.rsp_data} !== {2'b01, 8'h42}) begin
            miscompares++;
            $display("FAIL abort_done: valid/ready/data got %b/%b/%h expected 0/1/42",
                     host_if.rsp_valid, host_if.req_ready, host_if.rsp_data);
        end
        $display("abort_idle_done: idle abort ignored, done abort wins");
    endtask

    task automatic test_async_reset();
        logic [4:0] st;
        host_if.req_challenge = 8'h77;
        host_if.req_valid = 1'b1;
        step();
        host_if.req_valid = 1'b0;
        for (int k = 1; k < 6; k++) step();
        #2 rst_n = 1'b0;
        #1;
        st = {puf_reset, puf_en, host_if.rsp_valid, host_if.busy, host_if.req_ready};
        vectors++;
        if (st !== 5'b10000) begin
            miscompares++;
            $display("FAIL async_reset: status got %b expected 10000", st);
        end
        vectors++;
        if ({puf_challenge, host_if.rsp_data, host_if.rsp_unstable} !== 24'h0) begin
            miscompares++;
            $display("FAIL async_reset_data: chal/data/unst got %h expected 000000",
                     {puf_challenge, host_if.rsp_data, host_if.rsp_unstable});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        vectors++;
        if (host_if.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL async_release: req_ready got %b expected 1", host_if.req_ready);
        end
        $display("async_reset: mid-MEAS reset returned outputs to reset values");
    endtask

`ifdef PUF_MAJORITY_VOTE_EN
    task automatic test_vote();
        logic [7:0] vals [3];
        int p;
        int lat;
        vals[0] = 8'hF0;
        vals[1] = 8'hF1;
        vals[2] = 8'hF0;
        p = 0;
        host_if.req_challenge = 8'h11;
        host_if.req_valid = 1'b1;
        step();
        host_if.req_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            if (((k - 1) % 12 == 0) && (p < 3)) begin
                puf_response = vals[p];
                p++;
            end
            if (host_if.rsp_valid) begin
                lat = k;
                break;
            end
            step();
        end
        vectors++;
        if (lat != 37) begin
            miscompares++;
            $display("FAIL vote_lat: got %0d expected 37", lat);
        end
        vectors++;
        if ({host_if.rsp_data, host_if.rsp_unstable} !== 16'hF001) begin
            miscompares++;
            $display("FAIL vote_data: data/unst got %h/%h expected f0/01",
                     host_if.rsp_data, host_if.rsp_unstable);
        end
        host_if.rsp_ready = 1'b1;
        step();
        host_if.rsp_ready = 1'b0;
        $display("vote: f0/f1/f0 -> data %h unstable %h latency %0d",
                 host_if.rsp_data, host_if.rsp_unstable, lat);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_hold();
        test_abort_meas();
        test_abort_idle_done();
        test_async_reset();
`ifdef PUF_MAJORITY_VOTE_EN
        test_vote();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
